// File: rtl/memory_arbiter_if.sv
// Bundle of the core-facing (IF, DM) and memory-facing handshakes of memory_arbiter.
// slave = the arbiter's view, master = the surrounding core + memory.
interface memory_arbiter_if;
    logic        if_rd_en_i;
    logic [31:0] if_addr_i;
    logic [31:0] if_data_o;
    logic        if_ack_o;
    logic        dm_rd_en_i;
    logic        dm_wr_en_i;
    logic [31:0] dm_addr_i;
    logic [31:0] dm_data_i;
    logic [31:0] dm_data_o;
    logic        dm_ack_o;
    logic        err_o;
    logic        mem_rd_en_o;
    logic        mem_wr_en_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_data_o;
    logic [31:0] mem_data_i;
    logic        mem_ack_i;

    modport slave (
        input  if_rd_en_i, if_addr_i, dm_rd_en_i, dm_wr_en_i, dm_addr_i, dm_data_i,
               mem_data_i, mem_ack_i,
        output if_data_o, if_ack_o, dm_data_o, dm_ack_o, err_o,
               mem_rd_en_o, mem_wr_en_o, mem_addr_o, mem_data_o
    );

    modport master (
        output if_rd_en_i, if_addr_i, dm_rd_en_i, dm_wr_en_i, dm_addr_i, dm_data_i,
               mem_data_i, mem_ack_i,
        input  if_data_o, if_ack_o, dm_data_o, dm_ack_o, err_o,
               mem_rd_en_o, mem_wr_en_o, mem_addr_o, mem_data_o
    );
endinterface

// File: rtl/memory_arbiter.sv
// Round-robin arbiter sharing one single-port memory between the IF and DM ports.
// Optional `define MEM_ARB_TIMEOUT_EN aborts an access stalled for TIMEOUT_CYCLES cycles.
module memory_arbiter #(
    parameter bit RESET_PRIORITY = 1'b0,
    parameter int TIMEOUT_CYCLES = 16
) (
    input logic             clk,
    input logic             rst_n,
    memory_arbiter_if.slave bus
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("memory_arbiter: TIMEOUT_CYCLES must be at least 1");
    end

    state_t state;
    logic   last_grant;   // 0 = IF, 1 = DM; also selects the port being served
    logic   if_req, dm_req, pick_dm, to_hit;
    req_t   win_req;

    assign if_req  = bus.if_rd_en_i;
    assign dm_req  = bus.dm_rd_en_i | bus.dm_wr_en_i;
    // On a tie the port that did not win last time goes first.
    assign pick_dm = dm_req & (~if_req | ~last_grant);

    always_comb begin
        win_req = '{wr: 1'b0, addr: bus.if_addr_i, wdata: bus.mem_data_o};
        if (pick_dm)
            win_req = '{wr: bus.dm_wr_en_i, addr: bus.dm_addr_i, wdata: bus.dm_data_i};
    end

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] to_cnt;

    assign to_hit = (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt    <= '0;
            bus.err_o <= 1'b0;
        end else begin
            // err_o lines up with the RESP cycle of an access that ended without ack.
            bus.err_o <= (state == ACCESS) && !bus.mem_ack_i && to_hit;
            if (state != ACCESS)
                to_cnt <= '0;
            else if (!bus.mem_ack_i)
                to_cnt <= to_cnt + 1'b1;
        end
    end
`else
    assign to_hit    = 1'b0;
    assign bus.err_o = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            last_grant      <= ~RESET_PRIORITY;
            bus.mem_rd_en_o <= 1'b0;
            bus.mem_wr_en_o <= 1'b0;
            bus.mem_addr_o  <= '0;
            bus.mem_data_o  <= '0;
            bus.if_data_o   <= '0;
            bus.dm_data_o   <= '0;
            bus.if_ack_o    <= 1'b0;
            bus.dm_ack_o    <= 1'b0;
        end else begin
            bus.if_ack_o <= 1'b0;
            bus.dm_ack_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (if_req || dm_req) begin
                        last_grant      <= pick_dm;
                        bus.mem_rd_en_o <= ~win_req.wr;
                        bus.mem_wr_en_o <= win_req.wr;
                        bus.mem_addr_o  <= win_req.addr;
                        bus.mem_data_o  <= win_req.wdata;
                        state           <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (bus.mem_ack_i || to_hit) begin
                        bus.mem_rd_en_o <= 1'b0;
                        bus.mem_wr_en_o <= 1'b0;
                        state           <= RESP;
                        if (last_grant) bus.dm_ack_o <= 1'b1;
                        else            bus.if_ack_o <= 1'b1;
                        // Aborted accesses return zero; writes leave read data alone.
                        if (!bus.mem_ack_i) begin
                            if (last_grant) bus.dm_data_o <= '0;
                            else            bus.if_data_o <= '0;
                        end else if (bus.mem_rd_en_o) begin
                            if (last_grant) bus.dm_data_o <= bus.mem_data_i;
                            else            bus.if_data_o <= bus.mem_data_i;
                        end
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed + randomized bench for memory_arbiter against a transaction-level model.
`timescale 1ns/1ps
module tb_memory_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    memory_arbiter_if bus();

    memory_arbiter #(.RESET_PRIORITY(1'b0), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- memory model (stimulus side) ----------------
    logic [31:0] mem_arr [64];
    logic [31:0] ref_mem [64];
    int   mem_lat   = 0;
    int   mem_cnt   = 0;
    logic mem_stuck = 1'b0;
    logic mem_init  = 1'b0;

    always @(posedge clk or negedge rst_n)
        if (!rst_n) mem_cnt <= 0;
        else if ((bus.mem_rd_en_o | bus.mem_wr_en_o) && !bus.mem_ack_i) mem_cnt <= mem_cnt + 1;
        else mem_cnt <= 0;

    assign bus.mem_ack_i  = (bus.mem_rd_en_o | bus.mem_wr_en_o) && !mem_stuck && (mem_cnt >= mem_lat);
    assign bus.mem_data_i = mem_arr[bus.mem_addr_o[7:2]];

    always @(posedge clk)
        if (mem_init) for (int i = 0; i < 64; i++) mem_arr[i] <= 32'(i * 4 + 3);
        else if (bus.mem_wr_en_o && bus.mem_ack_i) mem_arr[bus.mem_addr_o[7:2]] <= bus.mem_data_o;

    // ---------------- monitors ----------------
    int if_acks = 0;
    int dm_acks = 0;
    always @(posedge clk) begin
        if (bus.if_ack_o) if_acks <= if_acks + 1;
        if (bus.dm_ack_o) dm_acks <= dm_acks + 1;
    end

    bit mon_en = 1'b0;
    always @(negedge clk)
        if (mon_en && rst_n) begin
            chk("ack_excl", 32'(bus.if_ack_o & bus.dm_ack_o), 32'd0);
            chk("en_excl", 32'(bus.mem_rd_en_o & bus.mem_wr_en_o), 32'd0);
            chk("err_idle", 32'(bus.err_o), 32'd0);
        end

    // ---------------- requester helpers ----------------
    task automatic drop_all();
        bus.if_rd_en_i = 1'b0;
        bus.dm_rd_en_i = 1'b0;
        bus.dm_wr_en_i = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drop_all();
        tick(2);
        rst_n = 1'b1;
    endtask

    task automatic run_txn(input bit dm, input bit wr, input logic [31:0] addr,
                           input logic [31:0] wdata, output logic [31:0] rdata);
        bit done = 1'b0;
        rdata = '0;
        if (dm) begin
            bus.dm_addr_i = addr; bus.dm_data_i = wdata;
            bus.dm_rd_en_i = ~wr; bus.dm_wr_en_i = wr;
        end else begin
            bus.if_addr_i = addr; bus.if_rd_en_i = 1'b1;
        end
        for (int i = 0; i < 300 && !done; i++) begin
            tick();
            if (dm ? bus.dm_ack_o : bus.if_ack_o) begin
                done = 1'b1;
                rdata = dm ? bus.dm_data_o : bus.if_data_o;
            end
        end
        drop_all();
        if (!done) chk("txn_timeout", 32'd0, 32'd1);
    endtask

    task automatic if_proc(input int n);
        for (int k = 0; k < n; k++) begin
            logic [5:0] w;
            int other0;
            bit done;
            tick($urandom_range(0, 3));
            w = 6'($urandom_range(0, 15));
            bus.if_addr_i = {24'h0, w, 2'b00};
            bus.if_rd_en_i = 1'b1;
            other0 = dm_acks;
            done = 1'b0;
            for (int i = 0; i < 200 && !done; i++) begin
                tick();
                if (bus.if_ack_o) done = 1'b1;
            end
            bus.if_rd_en_i = 1'b0;
            if (!done) chk("if_hang", 32'd0, 32'd1);
            else begin
                chk("if_rdata", bus.if_data_o, ref_mem[w]);
                chk("if_starve", 32'((dm_acks - other0) > 1), 32'd0);
            end
        end
    endtask

    task automatic dm_proc(input int n);
        for (int k = 0; k < n; k++) begin
            logic [5:0]  w;
            logic [31:0] d;
            bit wr, done;
            int other0;
            tick($urandom_range(0, 3));
            w  = 6'($urandom_range(0, 15));
            d  = $urandom;
            wr = 1'($urandom_range(0, 1));
            bus.dm_addr_i  = {24'h0, w, 2'b00};
            bus.dm_data_i  = d;
            bus.dm_wr_en_i = wr;
            bus.dm_rd_en_i = wr ? 1'($urandom_range(0, 1)) : 1'b1;
            other0 = if_acks;
            done = 1'b0;
            for (int i = 0; i < 200 && !done; i++) begin
                tick();
                if (bus.dm_ack_o) done = 1'b1;
            end
            bus.dm_rd_en_i = 1'b0;
            bus.dm_wr_en_i = 1'b0;
            if (!done) chk("dm_hang", 32'd0, 32'd1);
            else begin
                if (wr) ref_mem[w] = d;
                else    chk("dm_rdata", bus.dm_data_o, ref_mem[w]);
                chk("dm_starve", 32'((if_acks - other0) > 1), 32'd0);
            end
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] rd;
        bit rnd_done;
        int acc, ack_at, any_ack, any_err;
        logic [31:0] to_data;
        logic to_err;

        drop_all();
        bus.if_addr_i = '0; bus.dm_addr_i = '0; bus.dm_data_i = '0;
        for (int i = 0; i < 64; i++) ref_mem[i] = 32'(i * 4 + 3);
        mem_init = 1'b1;

        // reset state
        tick(2);
        mem_init = 1'b0;
        chk("rst_if_ack", 32'(bus.if_ack_o), 32'd0);
        chk("rst_dm_ack", 32'(bus.dm_ack_o), 32'd0);
        chk("rst_err", 32'(bus.err_o), 32'd0);
        chk("rst_mem_en", {30'd0, bus.mem_rd_en_o, bus.mem_wr_en_o}, 32'd0);
        chk("rst_mem_addr", bus.mem_addr_o, 32'd0);
        chk("rst_mem_data", bus.mem_data_o, 32'd0);
        chk("rst_if_data", bus.if_data_o, 32'd0);
        chk("rst_dm_data", bus.dm_data_o, 32'd0);

        // single IF read, combinational-ack memory
        rst_n = 1'b1;
        bus.if_addr_i = 32'h10; bus.if_rd_en_i = 1'b1;
        tick();
        chk("t1_c1_rd", 32'(bus.mem_rd_en_o), 32'd1);
        chk("t1_c1_wr", 32'(bus.mem_wr_en_o), 32'd0);
        chk("t1_c1_addr", bus.mem_addr_o, 32'h10);
        chk("t1_c1_ack", 32'(bus.if_ack_o), 32'd0);
        tick();
        chk("t1_c2_ack", 32'(bus.if_ack_o), 32'd1);
        chk("t1_c2_data", bus.if_data_o, 32'h13);
        chk("t1_c2_dmack", 32'(bus.dm_ack_o), 32'd0);
        chk("t1_c2_rd", 32'(bus.mem_rd_en_o), 32'd0);
        bus.if_rd_en_i = 1'b0;
        tick();
        chk("t1_c3_ack", 32'(bus.if_ack_o), 32'd0);
        chk("t1_c3_hold", bus.if_data_o, 32'h13);

        // DM write with rd and wr both high, then read back
        bus.dm_addr_i = 32'h20; bus.dm_data_i = 32'hCAFE_F00D;
        bus.dm_rd_en_i = 1'b1; bus.dm_wr_en_i = 1'b1;
        tick();
        chk("t2_wr", 32'(bus.mem_wr_en_o), 32'd1);
        chk("t2_rd", 32'(bus.mem_rd_en_o), 32'd0);
        chk("t2_wdata", bus.mem_data_o, 32'hCAFE_F00D);
        chk("t2_addr", bus.mem_addr_o, 32'h20);
        tick();
        chk("t2_ack", 32'(bus.dm_ack_o), 32'd1);
        chk("t2_ifack", 32'(bus.if_ack_o), 32'd0);
        drop_all();
        ref_mem[8] = 32'hCAFE_F00D;
        tick();
        run_txn(1'b1, 1'b0, 32'h20, 32'h0, rd);
        chk("t2_readback", rd, 32'hCAFE_F00D);
        tick();

        // both ports request continuously from reset: IF, DM, IF, DM every 3 cycles
        rst_n = 1'b0;
        bus.if_addr_i = 32'h10; bus.if_rd_en_i = 1'b1;
        bus.dm_addr_i = 32'h24; bus.dm_rd_en_i = 1'b1;
        tick(2);
        rst_n = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            tick();
            chk($sformatf("rr_if_ack_c%0d", c), 32'(bus.if_ack_o), 32'(c == 2 || c == 8));
            chk($sformatf("rr_dm_ack_c%0d", c), 32'(bus.dm_ack_o), 32'(c == 5 || c == 11));
            if (c == 2 || c == 8)  chk("rr_if_data", bus.if_data_o, 32'h13);
            if (c == 5 || c == 11) chk("rr_dm_data", bus.dm_data_o, 32'h27);
        end
        drop_all();
        tick(2);

        // memory acks after 4 cycles; DM arrives mid-access and waits
        mem_lat = 4;
        bus.if_addr_i = 32'h30; bus.if_rd_en_i = 1'b1;
        for (int c = 1; c <= 13; c++) begin
            tick();
            if (c == 1) begin bus.dm_addr_i = 32'h08; bus.dm_rd_en_i = 1'b1; end
            if (c <= 5) begin
                chk($sformatf("lat_rd_c%0d", c), 32'(bus.mem_rd_en_o), 32'd1);
                chk($sformatf("lat_addr_c%0d", c), bus.mem_addr_o, 32'h30);
                chk($sformatf("lat_ack_c%0d", c), 32'(bus.if_ack_o), 32'd0);
            end
            if (c == 6) begin
                chk("lat_if_ack", 32'(bus.if_ack_o), 32'd1);
                chk("lat_if_data", bus.if_data_o, 32'h33);
                chk("lat_rd_off", 32'(bus.mem_rd_en_o), 32'd0);
                bus.if_rd_en_i = 1'b0;
            end
            if (c == 8) begin
                chk("lat_dm_rd", 32'(bus.mem_rd_en_o), 32'd1);
                chk("lat_dm_addr", bus.mem_addr_o, 32'h08);
            end
            if (c == 12) chk("lat_dm_early", 32'(bus.dm_ack_o), 32'd0);
            if (c == 13) begin
                chk("lat_dm_ack", 32'(bus.dm_ack_o), 32'd1);
                chk("lat_dm_data", bus.dm_data_o, 32'h0B);
                bus.dm_rd_en_i = 1'b0;
            end
        end
        tick(2);

        // reset asserted during a DM read access
        bus.dm_addr_i = 32'h08; bus.dm_rd_en_i = 1'b1;
        tick(2);
        chk("ra_in_access", 32'(bus.mem_rd_en_o), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("ra_en", {30'd0, bus.mem_rd_en_o, bus.mem_wr_en_o}, 32'd0);
        chk("ra_acks", {30'd0, bus.if_ack_o, bus.dm_ack_o}, 32'd0);
        chk("ra_if_data", bus.if_data_o, 32'd0);
        chk("ra_dm_data", bus.dm_data_o, 32'd0);
        chk("ra_addr", bus.mem_addr_o, 32'd0);
        mem_lat = 0;
        bus.if_addr_i = 32'h14; bus.if_rd_en_i = 1'b1;
        bus.dm_addr_i = 32'h18; bus.dm_rd_en_i = 1'b1;
        tick(2);
        rst_n = 1'b1;
        tick();
        chk("ra_tie_addr", bus.mem_addr_o, 32'h14);
        tick();
        chk("ra_if_ack", 32'(bus.if_ack_o), 32'd1);
        chk("ra_if_rdata", bus.if_data_o, 32'h17);
        bus.if_rd_en_i = 1'b0;
        tick(3);
        chk("ra_dm_ack", 32'(bus.dm_ack_o), 32'd1);
        chk("ra_dm_rdata", bus.dm_data_o, 32'h1B);
        drop_all();
        tick(2);

        // memory never acks an IF read
        mem_stuck = 1'b1;
        bus.if_addr_i = 32'h10; bus.if_rd_en_i = 1'b1;
        acc = 0; ack_at = 0; any_ack = 0; any_err = 0;
        to_data = 32'hFFFF_FFFF; to_err = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
        for (int c = 1; c <= 40 && ack_at == 0; c++) begin
            tick();
            if (bus.mem_rd_en_o) acc++;
            if (bus.if_ack_o) begin
                ack_at = c; to_data = bus.if_data_o; to_err = bus.err_o;
                bus.if_rd_en_i = 1'b0;
            end
        end
        chk("to_access_cycles", 32'(acc), 32'd16);
        chk("to_ack_cycle", 32'(ack_at), 32'd17);
        chk("to_err", 32'(to_err), 32'd1);
        chk("to_data", to_data, 32'd0);
        tick();
        chk("to_err_pulse", 32'(bus.err_o), 32'd0);
`else
        for (int c = 1; c <= 100; c++) begin
            tick();
            if (bus.if_ack_o) any_ack++;
            if (bus.err_o) any_err++;
            if (bus.mem_rd_en_o) acc++;
        end
        chk("noto_ack", 32'(any_ack), 32'd0);
        chk("noto_err", 32'(any_err), 32'd0);
        chk("noto_waiting", 32'(acc), 32'd100);
`endif
        mem_stuck = 1'b0;

        // randomized traffic from both ports with random memory latency
        do_reset();
        mon_en = 1'b1;
        rnd_done = 1'b0;
        fork
            begin
                fork
                    if_proc(40);
                    dm_proc(40);
                join
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    tick();
                    if (!(bus.mem_rd_en_o | bus.mem_wr_en_o)) mem_lat = $urandom_range(0, 3);
                end
            end
        join
        mon_en = 1'b0;
        tick(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
